// File: rtl/branch_hazard_controller_if.sv
// rtl/branch_hazard_controller_if.sv - ID-stage hazard inputs and pipeline control outputs
interface branch_hazard_controller_if #(
  parameter int CNT_WIDTH = 16
);
  logic [5:0]           operation;
  logic [4:0]           idRs;
  logic [4:0]           idRt;
  logic                 IDEXMemRead;
  logic                 IDEXWriteSignal;
  logic [4:0]           IDEXWriteReg;
  logic                 EXMEMemRead;
  logic [4:0]           EXMEWriteReg;
  logic                 branchTaken;
  logic                 pcWrite;
  logic                 IFIDWrite;
  logic                 IDEXBubble;
  logic                 IFIDFlush;
  logic [CNT_WIDTH-1:0] stallCount;
  logic [CNT_WIDTH-1:0] flushCount;

  modport master (
    output operation, idRs, idRt, IDEXMemRead, IDEXWriteSignal, IDEXWriteReg,
           EXMEMemRead, EXMEWriteReg, branchTaken,
    input  pcWrite, IFIDWrite, IDEXBubble, IFIDFlush, stallCount, flushCount
  );

  modport slave (
    input  operation, idRs, idRt, IDEXMemRead, IDEXWriteSignal, IDEXWriteReg,
           EXMEMemRead, EXMEWriteReg, branchTaken,
    output pcWrite, IFIDWrite, IDEXBubble, IFIDFlush, stallCount, flushCount
  );
endinterface

// File: rtl/branch_hazard_controller.sv
// rtl/branch_hazard_controller.sv - decode-stage stall/flush sequencer for beq and load-use hazards
module branch_hazard_controller #(
  parameter logic [5:0] beqOperation = 6'b000100,
  parameter logic [5:0] lwOperation  = 6'b100011,
  parameter logic [5:0] swOperation  = 6'b101011,
  parameter logic [5:0] jOperation   = 6'b000010,
  parameter int         CNT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  branch_hazard_controller_if.slave bus
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  logic [1:0]           remain;
  logic [CNT_WIDTH-1:0] stallCnt;
  logic [CNT_WIDTH-1:0] flushCnt;

  logic       isBeq;
  logic       isJump;
  logic       rtIsSource;
  logic       matchEX;
  logic       matchMEM;
  logic [1:0] need;
  logic       stall;
  logic       flush;

  // A case decode sends X/unknown opcodes to the default arm, i.e. non-branch.
  always_comb begin
    isBeq      = 1'b0;
    isJump     = 1'b0;
    rtIsSource = 1'b0;
    case (bus.operation)
      6'b000000:    rtIsSource = 1'b1;
      beqOperation: begin
        isBeq      = 1'b1;
        rtIsSource = 1'b1;
      end
      swOperation:  rtIsSource = 1'b1;
      jOperation:   isJump     = 1'b1;
      lwOperation:  rtIsSource = 1'b0;
      default:      rtIsSource = 1'b0;
    endcase
  end

  always_comb begin
    matchEX  = bus.IDEXWriteSignal && (bus.IDEXWriteReg != 5'd0) &&
               ((bus.IDEXWriteReg == bus.idRs) ||
                (rtIsSource && (bus.IDEXWriteReg == bus.idRt)));
    matchMEM = bus.EXMEMemRead && (bus.EXMEWriteReg != 5'd0) &&
               ((bus.EXMEWriteReg == bus.idRs) ||
                (rtIsSource && (bus.EXMEWriteReg == bus.idRt)));
  end

  // beq compares in ID, so it waits longer than an EX-stage consumer would.
  always_comb begin
    need = 2'd0;
    if (state == IDLE) begin
      if (isBeq) begin
        if (matchEX && bus.IDEXMemRead)
          need = 2'd2;
        else if (matchEX || matchMEM)
          need = 2'd1;
      end else if (matchEX && bus.IDEXMemRead) begin
        need = 2'd1;
      end
    end
  end

  always_comb begin
    stall = rst_n && ((state == STALL) || (need != 2'd0));
    flush = rst_n && (state == IDLE) && (need == 2'd0) &&
            ((isBeq && bus.branchTaken) || isJump);
  end

  assign bus.pcWrite    = ~stall;
  assign bus.IFIDWrite  = ~stall;
  assign bus.IDEXBubble = stall;
  assign bus.IFIDFlush  = flush;
  assign bus.stallCount = stallCnt;
  assign bus.flushCount = flushCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      remain   <= 2'd0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // need==1 stays in IDLE: the next cycle's operands re-decide.
          if (need == 2'd2) begin
            state  <= STALL;
            remain <= 2'd1;
          end
        end
        STALL: begin
          remain <= remain - 2'd1;
          if (remain <= 2'd1)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (stall && (stallCnt != '1))
        stallCnt <= stallCnt + CNT_ONE;
      if (flush && (flushCnt != '1))
        flushCnt <= flushCnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_hazard_controller.sv
// tb/tb_branch_hazard_controller.sv - scoreboard bench for branch_hazard_controller
module tb_branch_hazard_controller;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic clk;
  logic rst_n;

  branch_hazard_controller_if #(.CNT_WIDTH(16)) bus ();
  branch_hazard_controller_if #(.CNT_WIDTH(4))  satBus ();

  branch_hazard_controller #(.CNT_WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  branch_hazard_controller #(.CNT_WIDTH(4)) dutSat (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (satBus.slave)
  );

  assign satBus.operation       = bus.operation;
  assign satBus.idRs            = bus.idRs;
  assign satBus.idRt            = bus.idRt;
  assign satBus.IDEXMemRead     = bus.IDEXMemRead;
  assign satBus.IDEXWriteSignal = bus.IDEXWriteSignal;
  assign satBus.IDEXWriteReg    = bus.IDEXWriteReg;
  assign satBus.EXMEMemRead     = bus.EXMEMemRead;
  assign satBus.EXMEWriteReg    = bus.EXMEWriteReg;
  assign satBus.branchTaken     = bus.branchTaken;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int pc;
    int bub;
    int fl;
    int s;
    int f;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   vecId  = 0;
  event sampleEv;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input int req);
    checks++;
    if (act !== 32'(req)) begin
      errors++;
      $display("FAIL %s vec%0d actual %0d required %0d", nm, id, act, req);
    end
  endtask

  task automatic setIn(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic exRd, input logic exWr, input logic [4:0] exReg,
                       input logic memRd, input logic [4:0] memReg, input logic tk);
    bus.operation       = op;
    bus.idRs            = rs;
    bus.idRt            = rt;
    bus.IDEXMemRead     = exRd;
    bus.IDEXWriteSignal = exWr;
    bus.IDEXWriteReg    = exReg;
    bus.EXMEMemRead     = memRd;
    bus.EXMEWriteReg    = memReg;
    bus.branchTaken     = tk;
  endtask

  task automatic push(input int pc, input int bub, input int fl, input int s, input int f);
    exp_t e;
    e.id = vecId; e.pc = pc; e.bub = bub; e.fl = fl; e.s = s; e.f = f;
    sbq.push_back(e);
    vecId++;
  endtask

  // One pipeline cycle: apply inputs just after the edge, release reset, queue the expectation.
  task automatic step(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic exRd, input logic exWr, input logic [4:0] exReg,
                      input logic memRd, input logic [4:0] memReg, input logic tk,
                      input int pc, input int bub, input int fl, input int s, input int f);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    setIn(op, rs, rt, exRd, exWr, exReg, memRd, memReg, tk);
    push(pc, bub, fl, s, f);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or sampleEv);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("pcWrite",    e.id, 32'(bus.pcWrite),    e.pc);
        chk("IFIDWrite",  e.id, 32'(bus.IFIDWrite),  e.pc);
        chk("IDEXBubble", e.id, 32'(bus.IDEXBubble), e.bub);
        chk("IFIDFlush",  e.id, 32'(bus.IFIDFlush),  e.fl);
        chk("stallCount", e.id, 32'(bus.stallCount), e.s);
        chk("flushCount", e.id, 32'(bus.flushCount), e.f);
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    setIn(OP_BEQ, 5'd12, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1);
    #2;
    push(1, 0, 0, 0, 0);
    #1 ->sampleEv;

    //    op      rs     rt     exRd exWr exReg  mRd  mReg   tk    pc bub fl  s  f
    step(OP_BEQ, 5'd12, 5'd9,  1'b1, 1'b1, 5'd9,  1'b0, 5'd0, 1'b0, 0, 1, 0, 0, 0);
    step(OP_BEQ, 5'd12, 5'd9,  1'b1, 1'b1, 5'd9,  1'b0, 5'd0, 1'b1, 0, 1, 0, 1, 0);
    step(OP_BEQ, 5'd12, 5'd9,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b1, 1, 0, 1, 2, 0);
    step(OP_R,   5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1, 0, 0, 2, 1);
    step(OP_BEQ, 5'd12, 5'd5,  1'b0, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 0, 1, 0, 2, 1);
    step(OP_BEQ, 5'd12, 5'd5,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1, 0, 0, 3, 1);
    step(OP_BEQ, 5'd1,  5'd9,  1'b0, 1'b1, 5'd4,  1'b1, 5'd9, 1'b0, 0, 1, 0, 3, 1);
    step(OP_BEQ, 5'd1,  5'd9,  1'b1, 1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 1, 0, 0, 4, 1);
    step(OP_R,   5'd3,  5'd7,  1'b1, 1'b1, 5'd3,  1'b0, 5'd0, 1'b0, 0, 1, 0, 4, 1);
    step(OP_SW,  5'd8,  5'd3,  1'b1, 1'b1, 5'd3,  1'b0, 5'd0, 1'b0, 0, 1, 0, 5, 1);
    step(OP_J,   5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1, 0, 1, 6, 1);
    step(OP_LW,  5'd2,  5'd9,  1'b1, 1'b1, 5'd9,  1'b0, 5'd0, 1'b1, 1, 0, 0, 6, 2);
    step(OP_BEQ, 5'd12, 5'd5,  1'b0, 1'b1, 5'd12, 1'b0, 5'd0, 1'b1, 0, 1, 0, 6, 2);
    step(6'bx,   5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b1, 1, 0, 0, 7, 2);
    step(OP_R,   5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1, 0, 0, 7, 2);
    step(OP_BEQ, 5'd12, 5'd9,  1'b1, 1'b1, 5'd9,  1'b0, 5'd0, 1'b0, 0, 1, 0, 7, 2);
    step(OP_BEQ, 5'd12, 5'd9,  1'b1, 1'b1, 5'd9,  1'b0, 5'd0, 1'b0, 0, 1, 0, 8, 2);

    // Reset lands mid-stall, away from any clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push(1, 0, 0, 0, 0);
    ->sampleEv;

    step(OP_R,   5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1, 0, 0, 0, 0);
    step(OP_R,   5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1, 0, 0, 0, 0);

    // Back-to-back single-cycle load-use stalls drive the 4-bit counter into saturation.
    for (int i = 0; i < 17; i++) begin
      step(OP_R, 5'd3, 5'd7, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 0, 1, 0, i, 0);
      if (i == 15) begin
        @(negedge clk);
        chk("satStallCount15", i, 32'(satBus.stallCount), 15);
      end
    end
    step(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1, 0, 0, 17, 0);
    @(negedge clk);
    chk("satStallCountHold", vecId, 32'(satBus.stallCount), 15);

    repeat (2) @(negedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboardDrain actual %0d required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_hazard_controller.md
Name: branch_hazard_controller

Overview:
- Decode-stage hazard sequencer for the 5-stage MIPS pipeline.
- Works alongside the ID-stage branch forwarding unit, which resolves beq operands early.
- Decides when a beq (or load-use consumer) cannot yet be served by forwarding. Stalls PC and IF/ID, injects ID/EX bubbles for the required number of cycles, then flushes IF/ID on a taken branch or jump.
- Keeps saturating stall/flush statistics counters.

Parameters:
- beqOperation, 6'b000100, opcode of beq
- lwOperation, 6'b100011, opcode of lw
- swOperation, 6'b101011, opcode of sw
- jOperation, 6'b000010, opcode of j
- CNT_WIDTH, 16, width of statistics counters

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- operation  in  6  opcode of instruction in ID
- idRs  in  5  rs field of ID instruction
- idRt  in  5  rt field of ID instruction
- IDEXMemRead  in  1  instruction in EX is a load
- IDEXWriteSignal  in  1  instruction in EX writes the register file
- IDEXWriteReg  in  5  destination register of instruction in EX
- EXMEMemRead  in  1  instruction in MEM is a load
- EXMEWriteReg  in  5  destination register of instruction in MEM
- branchTaken  in  1  ID comparator result (valid only when the operands are final)
- pcWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register enable
- IDEXBubble  out  1  zero ID/EX control fields this cycle
- IFIDFlush  out  1  clear IF/ID this cycle
- stallCount  out  CNT_WIDTH  total stall cycles, saturating
- flushCount  out  CNT_WIDTH  total flushes, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE, remain=0, stallCount=0, flushCount=0.
  - Outputs during reset: pcWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0.
  - Reset mid-stall aborts the stall immediately.
- Register 0 never creates a hazard.
- rt is a source only for operation 000000, beq and sw. rs is always a source.
- Match terms:
  - matchEX = IDEXWriteSignal, IDEXWriteReg!=0, and IDEXWriteReg equals a source.
  - matchMEM = EXMEMemRead, EXMEWriteReg!=0, and EXMEWriteReg equals a source.
- Required stalls, need (0..2), computed in IDLE:
  - operation==beq:
    - matchEX and IDEXMemRead -> 2
    - matchEX, ALU op -> 1
    - otherwise matchMEM -> 1
    - otherwise 0
  - Other opcodes:
    - matchEX and IDEXMemRead -> 1
    - otherwise 0
- FSM states: IDLE, STALL.
  - IDLE, need>0:
    - Same cycle (Mealy): pcWrite=0, IFIDWrite=0, IDEXBubble=1.
    - Next state: if need==2, go to STALL with remain=1. If need==1, stay IDLE; the hazard is re-evaluated next cycle.
  - STALL:
    - Outputs: pcWrite=0, IFIDWrite=0, IDEXBubble=1. Hazard inputs and branchTaken are ignored.
    - Decrement remain. When remain reaches 0, return to IDLE.
  - IDLE, need==0:
    - No stall.
    - IFIDFlush=1 when (operation==beq and branchTaken) or operation==jOperation.
    - The flush is Mealy, same cycle as branch resolution.
- A stall always overrides a flush. IFIDFlush=0 in any cycle where pcWrite=0.
- Exactly one of (stall, flush, idle) per cycle. A flush never coincides with a bubble.
- Counters update on the rising edge:
  - stallCount +1 each cycle pcWrite=0.
  - flushCount +1 each cycle IFIDFlush=1.
  - Both saturate at all-ones and never wrap.
- Latency: zero-cycle (combinational) stall and flush outputs; counters lag by one edge.
- Unknown or X opcode is treated as a non-branch.

Test Plan:
- beq rs=12, rt=9; EX is lw writing 9 -> pcWrite=0 for exactly 2 cycles, IDEXBubble=1 both cycles, stallCount=2. Then with branchTaken=1: IFIDFlush=1 for 1 cycle, flushCount=1.
- beq rs=12; EX is ALU writing 12 with IDEXWriteSignal=1 -> 1 stall cycle. Next cycle no hazard, branchTaken=0 -> IFIDFlush=0.
- beq rt=9; MEM is lw writing 9; EX has no match -> 1 stall. beq with EX lw writing 0 -> no stall.
- add rs=3; EX lw writing 3 -> 1 stall. sw rt=3; EX lw writing 3 -> 1 stall. j -> IFIDFlush=1, no stall.
- Assert rst_n=0 during the second cycle of a 2-cycle stall -> pcWrite=1, state=IDLE, counters=0 immediately without a clock edge.
- Force stallCount to all-ones (CNT_WIDTH=4 build), then one more stall -> stays 4'hF.
